multdiv_arbiter: RTL and testbench

//  Shares one multi-cycle multdiv unit between two requesters (req0 has priority at reset, then round-robin).

---
 rtl/multdiv_arbiter.sv | 165 ++++++++++++++++
 tb/tb_multdiv_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_arbiter.sv
// Two-requester front end for a shared multi-cycle multdiv unit: round-robin grant,
// operand capture, start pulse, ready/timeout wait and a one-cycle completion response.
`timescale 1ns/1ps
module multdiv_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 100,
    parameter int CNT_W   = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             op0,
    input  logic             op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             timeout,
    output logic             busy,
    output logic [WIDTH-1:0] md_operandA,
    output logic [WIDTH-1:0] md_operandB,
    output logic             md_ctrl_MULT,
    output logic             md_ctrl_DIV,
    input  logic [WIDTH-1:0] md_result,
    input  logic             md_exception,
    input  logic             md_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             winner_q, winner_d;
    logic             last_grant_q, last_grant_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;
    logic             tout_q, tout_d;

    // Requester inputs gathered into indexable form so the grant selects by id.
    logic [1:0]       req_vec;
    logic             op_vec [2];
    logic [WIDTH-1:0] a_vec  [2];
    logic [WIDTH-1:0] b_vec  [2];
    logic [1:0]       done_vec;
    logic             grant_id;

    assign req_vec  = {req1, req0};
    assign op_vec[0] = op0;
    assign op_vec[1] = op1;
    assign a_vec[0]  = a0;
    assign a_vec[1]  = a1;
    assign b_vec[0]  = b0;
    assign b_vec[1]  = b1;

    // On contention the requester that was not served last wins; otherwise whoever asks.
    assign grant_id = (req0 && req1) ? ~last_grant_q : req1;

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        exc_d        = exc_q;
        tout_d       = tout_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    winner_d     = grant_id;
                    last_grant_d = grant_id;
                    op_d         = op_vec[grant_id];
                    opa_d        = a_vec[grant_id];
                    opb_d        = b_vec[grant_id];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A ready seen in the first wait cycle may belong to the previous operation.
                if (md_ready && (cnt_q != '0)) begin
                    res_d   = md_result;
                    exc_d   = md_exception;
                    tout_d  = 1'b0;
                    state_d = ST_RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    exc_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            cnt_q        <= '0;
            res_q        <= '0;
            exc_q        <= 1'b0;
            tout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            exc_q        <= exc_d;
            tout_q       <= tout_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_done
        assign done_vec[gi] = (state_q == ST_RESPOND) && (winner_q == 1'(gi));
    end

    assign done0        = done_vec[0];
    assign done1        = done_vec[1];
    assign busy         = (state_q != ST_IDLE);
    assign md_operandA  = opa_q;
    assign md_operandB  = opb_q;
    assign md_ctrl_MULT = (state_q == ST_ISSUE) && !op_q;
    assign md_ctrl_DIV  = (state_q == ST_ISSUE) && op_q;
    // Response fields are only meaningful alongside done; they read zero otherwise.
    assign result       = (state_q == ST_RESPOND) ? res_q : '0;
    assign exception    = (state_q == ST_RESPOND) && exc_q;
    assign timeout      = (state_q == ST_RESPOND) && tout_q;

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Scoreboard bench for multdiv_arbiter with a behavioural multdiv stub and two queued requesters.
`timescale 1ns/1ps
module tb_multdiv_arbiter;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 100;
    localparam int CNT_W   = 7;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [WIDTH-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic             done0, done1, exception, timeout, busy;
    logic [WIDTH-1:0] result, md_operandA, md_operandB;
    logic             md_ctrl_MULT, md_ctrl_DIV;
    logic [WIDTH-1:0] md_result = '0;
    logic             md_exception = 1'b0;
    logic             md_ready;

    always #5 clock = ~clock;

    multdiv_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .done0(done0), .done1(done1), .result(result), .exception(exception),
        .timeout(timeout), .busy(busy),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Multdiv reference: {exception, result}
    function automatic logic [WIDTH:0] md_model(input logic op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa, sb_v, r;
        sa = a;
        sb_v = b;
        if (!op) begin
            r = sa * sb_v;
            return {1'b0, r};
        end
        if (b == '0) return {1'b1, {WIDTH{1'b0}}};
        r = sa / sb_v;
        return {1'b0, r};
    endfunction

    typedef struct {
        logic             id;
        logic             op;
        logic [WIDTH-1:0] a, b, res;
        logic             exc, tout;
        int               lat;
    } exp_t;
    typedef struct {
        logic             op;
        logic [WIDTH-1:0] a, b;
    } req_t;

    exp_t sb[$];
    req_t rq0[$], rq1[$];

    // Stub mode: 0 = one-cycle ready after lat, 1 = never ready, 2 = ready stuck high
    int mode = 0;
    int lat = 3;
    int sc = 0;
    logic             rdy_pulse = 1'b0;
    logic [WIDTH-1:0] pend_r = '0;
    logic             pend_e = 1'b0;

    assign md_ready = (mode == 2) ? 1'b1 : rdy_pulse;

    always @(posedge clock) begin
        rdy_pulse <= 1'b0;
        if (sc == 1) begin
            md_result    <= pend_r;
            md_exception <= pend_e;
            rdy_pulse    <= (mode == 0);
        end
        if (sc > 0) sc <= sc - 1;
        if (md_ctrl_MULT || md_ctrl_DIV) begin
            {pend_e, pend_r} <= md_model(md_ctrl_DIV, md_operandA, md_operandB);
            sc <= lat - 1;
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Requesters: hold req until done, then immediately present the next queued op if any.
    always @(negedge clock) begin
        req_t r;
        if (reset) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end else begin
            if (done0 || !req0) begin
                if (rq0.size() > 0) begin
                    r = rq0.pop_front();
                    op0 = r.op; a0 = r.a; b0 = r.b; req0 = 1'b1;
                end else req0 = 1'b0;
            end
            if (done1 || !req1) begin
                if (rq1.size() > 0) begin
                    r = rq1.pop_front();
                    op1 = r.op; a1 = r.a; b1 = r.b; req1 = 1'b1;
                end else req1 = 1'b0;
            end
        end
    end

    int   issue_cyc = 0;
    logic prev_ctrl = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        logic ctrl;
        ctrl = md_ctrl_MULT | md_ctrl_DIV;
        if (!reset) begin
            if (ctrl) begin
                check_eq("ctrl_one_cycle", prev_ctrl, 1'b0);
                if (sb.size() == 0) check_eq("issue_unexpected", 1, 0);
                else begin
                    check_eq("ctrl_mult", md_ctrl_MULT, !sb[0].op);
                    check_eq("ctrl_div", md_ctrl_DIV, sb[0].op);
                    check_eq("operandA", md_operandA, sb[0].a);
                    check_eq("operandB", md_operandB, sb[0].b);
                end
                issue_cyc = cyc;
            end
            if (done0 || done1) begin
                check_eq("done_both", done0 & done1, 1'b0);
                if (sb.size() == 0) check_eq("done_unexpected", {done1, done0}, 2'b00);
                else begin
                    e = sb.pop_front();
                    $display("done id=%0d result=%0d exc=%0b tout=%0b lat=%0d", done1,
                             $signed(result), exception, timeout, cyc - issue_cyc);
                    check_eq("done_id", done1, e.id);
                    check_eq("result", result, e.res);
                    check_eq("exception", exception, e.exc);
                    check_eq("timeout", timeout, e.tout);
                    check_eq("issue_to_done", 64'(cyc - issue_cyc), 64'(e.lat));
                end
            end else begin
                check_eq("idle_response_zero", {result, exception, timeout}, '0);
            end
        end
        prev_ctrl = ctrl;
    end

    task automatic submit(input logic id, input logic op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        exp_t e;
        req_t r;
        logic [WIDTH:0] m;
        e.id = id; e.op = op; e.a = a; e.b = b;
        if (mode == 1) begin
            e.res = '0; e.exc = 1'b1; e.tout = 1'b1; e.lat = TIMEOUT + 1;
        end else begin
            m = md_model(op, a, b);
            e.res = m[WIDTH-1:0]; e.exc = m[WIDTH]; e.tout = 1'b0; e.lat = lat + 1;
        end
        sb.push_back(e);
        r.op = op; r.a = a; r.b = b;
        if (id) rq1.push_back(r);
        else rq0.push_back(r);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || rq0.size() != 0 || rq1.size() != 0 || busy || req0 || req1)
               && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_eq("drain_in_budget", n < budget, 1'b1);
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", {done1, done0}, 2'b00);
        check_eq("rst_ctrl", {md_ctrl_DIV, md_ctrl_MULT}, 2'b00);
        check_eq("rst_operands", {md_operandA, md_operandB}, '0);
        check_eq("rst_response", {result, exception, timeout}, '0);
        reset = 1'b0;

        // single multiply from requester 0
        lat = 3;
        submit(1'b0, 1'b0, 32'd7, -32'sd3);
        drain(200);

        // divide by zero from requester 1
        lat = 2;
        submit(1'b1, 1'b1, 32'd5, 32'd0);
        drain(200);

        // contention from reset: 0 first, then 1, then re-raised 0 waits its turn
        pulse_reset();
        @(posedge clock);
        lat = 4;
        submit(1'b0, 1'b0, 32'd6, 32'd7);
        submit(1'b1, 1'b1, 32'd100, 32'd7);
        submit(1'b0, 1'b0, 32'd9, 32'd9);
        drain(300);
        // last grant was 0, so simultaneous requests now favour 1
        @(posedge clock);
        submit(1'b1, 1'b0, 32'd3, -32'sd5);
        submit(1'b0, 1'b1, -32'sd8, 32'd2);
        drain(300);

        // no ready at all: forced completion
        mode = 1;
        submit(1'b1, 1'b0, 32'd2, 32'd3);
        drain(500);

        // ready stuck high from the previous op must be masked in the first wait cycle
        mode = 2;
        lat = 2;
        submit(1'b0, 1'b0, 32'd5, 32'd5);
        drain(200);
        mode = 0;

        // reset in the middle of a wait
        mode = 1;
        submit(1'b0, 1'b0, 32'd1, 32'd1);
        n = 0;
        while (!md_ctrl_MULT && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_eq("abort_issue_seen", n < 50, 1'b1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", {done1, done0}, 2'b00);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        mode = 0;
        lat = 3;
        repeat (20) @(negedge clock);
        check_eq("abort_quiet", busy, 1'b0);
        submit(1'b0, 1'b0, 32'd4, 32'd4);
        drain(200);

        check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got=expired expected=finish");
        $fatal(1, "time limit");
    end

endmodule
